axis_pkt_fifo: RTL and testbench

AXIS_PKT_FIFO -- requirements
Module: axis_pkt_fifo

---
 rtl/axis_pkt_fifo.sv | 108 ++++++++++
 tb/tb_axis_pkt_fifo.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_fifo.sv
// AXI-Stream FIFO of DEPTH {tdata,tlast} entries with optional store-and-forward gating.
// Latency: a beat written on edge N is visible on s_* after edge N (no empty bypass).
// Backpressure: m_tready drops when full; s_tvalid waits for a whole packet in packet mode.
module axis_pkt_fifo #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_DEPTH   = 4,
  parameter int PACKET_MODE  = 0,
  parameter int AFULL_THRESH = 12
) (
  input  logic                  aclk,
  input  logic                  areset_n,
  input  logic [DATA_WIDTH-1:0] m_tdata,
  input  logic                  m_tvalid,
  output logic                  m_tready,
  input  logic                  m_tlast,
  output logic [DATA_WIDTH-1:0] s_tdata,
  output logic                  s_tvalid,
  input  logic                  s_tready,
  output logic                  s_tlast,
  output logic [ADDR_DEPTH:0]   fill_count,
  output logic [ADDR_DEPTH:0]   pkt_count,
  output logic                  almost_full
);

  localparam int               DEPTH     = 1 << ADDR_DEPTH;
  localparam int               PW        = ADDR_DEPTH + 1;
  localparam logic [PW-1:0]    DEPTH_LVL = PW'(DEPTH);
  localparam logic [PW-1:0]    AFULL_LVL = PW'(AFULL_THRESH);

  // Storage is never reset: pointers alone define which entries are live.
  logic [DATA_WIDTH:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic          rst_done_q;

  logic          full;
  logic          empty;
  logic          wr_en;
  logic          rd_en;
  logic          head_last;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fill_count  = wr_ptr_q - rd_ptr_q;
  assign pkt_count   = pkt_cnt_q;
  assign full        = (fill_count == DEPTH_LVL);
  assign empty       = (fill_count == '0);
  assign almost_full = (fill_count >= AFULL_LVL);

  assign m_tready    = rst_done_q && !full;
  assign wr_en       = m_tvalid && m_tready;
  assign rd_en       = s_tvalid && s_tready;

  assign s_tdata     = mem_q[rd_ptr_q[ADDR_DEPTH-1:0]][DATA_WIDTH-1:0];
  assign head_last   = mem_q[rd_ptr_q[ADDR_DEPTH-1:0]][DATA_WIDTH];
  assign s_tlast     = head_last;

  // Output gating: cut-through shows any stored beat; store-and-forward waits
  // for a complete packet, except when full (otherwise an oversized packet deadlocks).
  always_comb begin
    s_tvalid = !empty;
    if (PACKET_MODE != 0) begin
      s_tvalid = !empty && ((pkt_cnt_q != '0) || full);
    end
  end

  // Next-state for pointers and the stored-packet counter.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    pkt_cnt_d = pkt_cnt_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if ((wr_en && m_tlast) && !(rd_en && head_last)) begin
      pkt_cnt_d = pkt_cnt_q + 1'b1;
    end else if (!(wr_en && m_tlast) && (rd_en && head_last)) begin
      pkt_cnt_d = pkt_cnt_q - 1'b1;
    end
  end

  // Control state; rst_done holds off writes until the first edge after reset release.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pkt_cnt_q  <= '0;
      rst_done_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pkt_cnt_q  <= pkt_cnt_d;
      rst_done_q <= 1'b1;
    end
  end

  // Beat storage write port.
  always_ff @(posedge aclk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[ADDR_DEPTH-1:0]] <= {m_tlast, m_tdata};
    end
  end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Scoreboard bench for axis_pkt_fifo: a stream-mode and a packet-mode instance.
// Stimulus pushes expected beats; per-instance monitors pop on each s_* handshake.
// Status outputs are checked directly against hand-computed values.
module tb_axis_pkt_fifo;
  localparam int DW = 8;
  localparam int AD = 4;

  logic aclk = 1'b0;
  logic areset_n = 1'b0;
  always #5 aclk = ~aclk;

  // Stream-mode instance (a_*)
  logic [DW-1:0] a_m_tdata = '0;
  logic          a_m_tvalid = 1'b0, a_m_tlast = 1'b0, a_m_tready;
  logic [DW-1:0] a_s_tdata;
  logic          a_s_tvalid, a_s_tlast, a_s_tready = 1'b0;
  logic [AD:0]   a_fill, a_pkt;
  logic          a_afull;

  // Packet-mode instance (b_*)
  logic [DW-1:0] b_m_tdata = '0;
  logic          b_m_tvalid = 1'b0, b_m_tlast = 1'b0, b_m_tready;
  logic [DW-1:0] b_s_tdata;
  logic          b_s_tvalid, b_s_tlast, b_s_tready = 1'b0;
  logic [AD:0]   b_fill, b_pkt;
  logic          b_afull;

  axis_pkt_fifo #(.DATA_WIDTH(DW), .ADDR_DEPTH(AD), .PACKET_MODE(0), .AFULL_THRESH(12)) dut_a (
    .aclk(aclk), .areset_n(areset_n),
    .m_tdata(a_m_tdata), .m_tvalid(a_m_tvalid), .m_tready(a_m_tready), .m_tlast(a_m_tlast),
    .s_tdata(a_s_tdata), .s_tvalid(a_s_tvalid), .s_tready(a_s_tready), .s_tlast(a_s_tlast),
    .fill_count(a_fill), .pkt_count(a_pkt), .almost_full(a_afull));

  axis_pkt_fifo #(.DATA_WIDTH(DW), .ADDR_DEPTH(AD), .PACKET_MODE(1), .AFULL_THRESH(12)) dut_b (
    .aclk(aclk), .areset_n(areset_n),
    .m_tdata(b_m_tdata), .m_tvalid(b_m_tvalid), .m_tready(b_m_tready), .m_tlast(b_m_tlast),
    .s_tdata(b_s_tdata), .s_tvalid(b_s_tvalid), .s_tready(b_s_tready), .s_tlast(b_s_tlast),
    .fill_count(b_fill), .pkt_count(b_pkt), .almost_full(b_afull));

  int checks = 0;
  int errors = 0;
  logic [DW:0] q_a[$];
  logic [DW:0] q_b[$];
  logic [DW:0] exp_a, exp_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Monitors: handshake condition is stable from posedge+1 to the next posedge.
  always @(negedge aclk) begin
    if (areset_n && a_s_tvalid && a_s_tready) begin
      checks++;
      if (q_a.size() == 0) begin
        errors++;
        $display("FAIL mon_a: unexpected beat got %0h expected none", {a_s_tlast, a_s_tdata});
      end else begin
        exp_a = q_a.pop_front();
        if ({a_s_tlast, a_s_tdata} !== exp_a) begin
          errors++;
          $display("FAIL mon_a: got %0h expected %0h", {a_s_tlast, a_s_tdata}, exp_a);
        end
      end
    end
  end

  always @(negedge aclk) begin
    if (areset_n && b_s_tvalid && b_s_tready) begin
      checks++;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL mon_b: unexpected beat got %0h expected none", {b_s_tlast, b_s_tdata});
      end else begin
        exp_b = q_b.pop_front();
        if ({b_s_tlast, b_s_tdata} !== exp_b) begin
          errors++;
          $display("FAIL mon_b: got %0h expected %0h", {b_s_tlast, b_s_tdata}, exp_b);
        end
      end
    end
  end

  // Write one beat, waiting (bounded) for m_tready; push the expectation if asked.
  task automatic wr(input bit sel, input logic [DW-1:0] d, input bit l, input bit push);
    int n;
    n = 0;
    if (!sel) begin a_m_tvalid = 1'b1; a_m_tdata = d; a_m_tlast = l; end
    else      begin b_m_tvalid = 1'b1; b_m_tdata = d; b_m_tlast = l; end
    while (!(sel ? b_m_tready : a_m_tready) && n < 200) begin
      tick();
      n++;
    end
    if (n == 200) begin
      checks++;
      errors++;
      $display("FAIL wr_timeout: m_tready stayed 0 for data %0h", d);
    end else begin
      if (push) begin
        if (!sel) q_a.push_back({l, d});
        else      q_b.push_back({l, d});
      end
      tick();
    end
    if (!sel) a_m_tvalid = 1'b0;
    else      b_m_tvalid = 1'b0;
  endtask

  // Read until empty with a cycle budget.
  task automatic drain(input bit sel);
    int n;
    n = 0;
    if (!sel) a_s_tready = 1'b1; else b_s_tready = 1'b1;
    while (((sel ? b_fill : a_fill) != 0) && n < 300) begin
      tick();
      n++;
    end
    if (n == 300) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: fill stuck at %0d expected 0", sel ? b_fill : a_fill);
    end
    if (!sel) a_s_tready = 1'b0; else b_s_tready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    #2;
    check("rst_fill", a_fill, 0);
    check("rst_pkt", a_pkt, 0);
    check("rst_svalid", a_s_tvalid, 0);
    check("rst_mready", a_m_tready, 0);
    check("rst_afull", a_afull, 0);
    tick();
    areset_n = 1'b1;
    check("rel_mready_before_edge", a_m_tready, 0);
    tick();
    check("rel_mready_a", a_m_tready, 1);
    check("rel_mready_b", b_m_tready, 1);
    check("idle_svalid", a_s_tvalid, 0);

    // Stream: three beats, tlast on the third
    wr(0, 8'h11, 0, 1);
    check("s_first_svalid", a_s_tvalid, 1);
    check("s_first_fill", a_fill, 1);
    wr(0, 8'h22, 0, 1);
    wr(0, 8'h33, 1, 1);
    check("s3_fill", a_fill, 3);
    check("s3_pkt", a_pkt, 1);
    drain(0);
    check("s3_fill_after", a_fill, 0);
    check("s3_pkt_after", a_pkt, 0);
    check("s3_svalid_after", a_s_tvalid, 0);

    // Full, almost_full, then wrap
    for (int i = 0; i < 16; i++) begin
      wr(0, 8'h40 + 8'(i), 0, 1);
      check("full_fill", a_fill, 32'(i + 1));
      check("full_afull", a_afull, (i + 1 >= 12) ? 1 : 0);
    end
    check("full_mready", a_m_tready, 0);
    check("full_svalid", a_s_tvalid, 1);
    a_m_tvalid = 1'b1; a_m_tdata = 8'hEE; a_m_tlast = 1'b0; a_s_tready = 1'b1;
    tick();
    a_m_tvalid = 1'b0; a_s_tready = 1'b0;
    check("full_rd_fill", a_fill, 15);
    check("full_rd_mready", a_m_tready, 1);
    a_s_tready = 1'b1;
    for (int i = 0; i < 16; i++) wr(0, 8'h50 + 8'(i), 0, 1);
    drain(0);
    check("wrap_fill", a_fill, 0);
    check("wrap_afull", a_afull, 0);

    // Simultaneous tlast read and tlast write
    wr(0, 8'h61, 1, 1);
    for (int i = 2; i < 6; i++) wr(0, 8'h60 + 8'(i), 0, 1);
    check("sim_pre_fill", a_fill, 5);
    check("sim_pre_pkt", a_pkt, 1);
    a_s_tready = 1'b1;
    a_m_tvalid = 1'b1; a_m_tdata = 8'h66; a_m_tlast = 1'b1;
    q_a.push_back({1'b1, 8'h66});
    tick();
    a_m_tvalid = 1'b0; a_s_tready = 1'b0;
    check("sim_fill", a_fill, 5);
    check("sim_pkt", a_pkt, 1);
    drain(0);
    check("sim_pkt_after", a_pkt, 0);

    // Reset mid-packet
    for (int i = 0; i < 7; i++) wr(0, 8'h30 + 8'(i), 0, 0);
    check("mid_fill", a_fill, 7);
    areset_n = 1'b0;
    #1;
    check("mid_rst_fill", a_fill, 0);
    check("mid_rst_svalid", a_s_tvalid, 0);
    check("mid_rst_mready", a_m_tready, 0);
    check("mid_rst_pkt", a_pkt, 0);
    tick();
    tick();
    areset_n = 1'b1;
    check("mid_rel_mready0", a_m_tready, 0);
    tick();
    check("mid_rel_mready1", a_m_tready, 1);
    wr(0, 8'h71, 0, 1);
    wr(0, 8'h72, 1, 1);
    check("post_rst_pkt", a_pkt, 1);
    drain(0);
    check("post_rst_pkt_after", a_pkt, 0);

    // Packet mode: held until tlast written
    wr(1, 8'h81, 0, 1);
    check("p1_svalid", b_s_tvalid, 0);
    wr(1, 8'h82, 0, 1);
    check("p2_svalid", b_s_tvalid, 0);
    wr(1, 8'h83, 0, 1);
    check("p3_svalid", b_s_tvalid, 0);
    wr(1, 8'h84, 1, 1);
    check("p4_svalid", b_s_tvalid, 1);
    check("p4_pkt", b_pkt, 1);
    drain(1);
    check("p_fill_after", b_fill, 0);
    check("p_pkt_after", b_pkt, 0);

    // Packet mode deadlock escape
    for (int i = 0; i < 16; i++) begin
      wr(1, 8'h90 + 8'(i), 0, 1);
      if (i == 14) check("dl_15_svalid", b_s_tvalid, 0);
    end
    check("dl_full_svalid", b_s_tvalid, 1);
    check("dl_full_mready", b_m_tready, 0);
    check("dl_full_fill", b_fill, 16);
    b_s_tready = 1'b1;
    tick();
    b_s_tready = 1'b0;
    check("dl_rd_svalid", b_s_tvalid, 0);
    check("dl_rd_mready", b_m_tready, 1);
    check("dl_rd_fill", b_fill, 15);
    wr(1, 8'hA0, 1, 1);
    check("dl_last_svalid", b_s_tvalid, 1);
    drain(1);

    check("q_a_empty", q_a.size(), 0);
    check("q_b_empty", q_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
